// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_PORTS = 2;

    typedef logic port_id_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // One stage of the read-owner pipeline.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_stage_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter; suffixes are as seen from the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [1:0]            req_i;
    logic [1:0]            we_i;
    logic [1:0]            lock_i;
    logic [ADDR_WIDTH-1:0] addr0_i;
    logic [ADDR_WIDTH-1:0] addr1_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0] rdata0_o;
    logic [DATA_WIDTH-1:0] rdata1_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_value_o;
    logic [DATA_WIDTH-1:0] mem_value_i;
    logic                  mem_enable_o;
    logic                  mem_wr_en_o;
    logic                  mem_rd_en_o;

    modport slave (
        input  req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_value_i,
        output gnt_o, rvalid_o, rdata0_o, rdata1_o, mem_addr_o, mem_value_o,
               mem_enable_o, mem_wr_en_o, mem_rd_en_o
    );

    modport master (
        output req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_value_i,
        input  gnt_o, rvalid_o, rdata0_o, rdata1_o, mem_addr_o, mem_value_o,
               mem_enable_o, mem_wr_en_o, mem_rd_en_o
    );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way pick. ARB_ROUND_ROBIN_EN selects round-robin on contention,
// otherwise fixed priority with port 0 highest.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  port_id_t             last_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;
    assign gnt_o       = {req_i[1] & ~req_i[0], req_i[0]};
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory with bounded burst locking.
// Contention policy is chosen by ARB_ROUND_ROBIN_EN (see mem_arb_rr_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_LOCK   = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

    arb_state_t            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    port_id_t              last_q, last_d;
    rd_stage_t             rd1_q, rd1_d, rd2_q;
    logic [1:0]            pick, gnt, rvalid;
    logic                  acc, acc_we;
    port_id_t              acc_port, lock_port;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_value_q, mem_value_d;
    logic                  mem_en_q, mem_en_d, mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q, rdata0, rdata1;

    mem_arb_rr_pick u_pick (
        .req_i  (bus.req_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    assign lock_port = port_id_t'(state_q == LOCK1);

    always_comb begin
        gnt = '0;
        unique case (state_q)
            ARB:     gnt = pick;
            LOCK0:   gnt = {1'b0, bus.req_i[0]};
            LOCK1:   gnt = {bus.req_i[1], 1'b0};
            default: gnt = '0;
        endcase
        if (rst_i) begin
            gnt = '0;
        end
    end

    assign acc      = |gnt;
    assign acc_port = port_id_t'(gnt[1]);
    assign acc_we   = bus.we_i[acc_port];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        unique case (state_q)
            ARB: begin
                if (acc) begin
                    last_d = acc_port;
                    if (bus.lock_i[acc_port] && MAX_LOCK > 1) begin
                        state_d = acc_port ? LOCK1 : LOCK0;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (acc) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // A grant issued while lock drops still completes as the burst's final access.
                if (!bus.lock_i[lock_port] || (acc && (cnt_q + CntW'(1)) == CntW'(MAX_LOCK))) begin
                    state_d = ARB;
                    cnt_d   = '0;
                    last_d  = lock_port;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        mem_en_d    = acc;
        mem_wr_d    = acc & acc_we;
        mem_rd_d    = acc & ~acc_we;
        mem_addr_d  = '0;
        mem_value_d = '0;
        if (acc) begin
            mem_addr_d = acc_port ? bus.addr1_i : bus.addr0_i;
            if (acc_we) begin
                mem_value_d = acc_port ? bus.wdata1_i : bus.wdata0_i;
            end
        end
        rd1_d = '{valid: acc & ~acc_we, port: acc_port};
    end

    always_comb begin
        rvalid = '0;
        if (rd2_q.valid && !rst_i) begin
            rvalid[rd2_q.port] = 1'b1;
        end
    end

    assign rdata0 = rvalid[0] ? bus.mem_value_i : rdata0_q;
    assign rdata1 = rvalid[1] ? bus.mem_value_i : rdata1_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            rd1_q       <= '0;
            rd2_q       <= '0;
            mem_addr_q  <= '0;
            mem_value_q <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd1_q;
            mem_addr_q  <= mem_addr_d;
            mem_value_q <= mem_value_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rdata0_q    <= rdata0;
            rdata1_q    <= rdata1;
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.rvalid_o     = rvalid;
    assign bus.rdata0_o     = rdata0;
    assign bus.rdata1_o     = rdata1;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_value_o  = mem_value_q;
    assign bus.mem_enable_o = mem_en_q;
    assign bus.mem_wr_en_o  = mem_wr_q;
    assign bus.mem_rd_en_o  = mem_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous 16-bit memory.
// Contention expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (16),
        .MAX_LOCK   (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    logic [15:0] ram [0:4095];

    always @(posedge clk_i) begin
        if (bus.mem_enable_o && bus.mem_wr_en_o) ram[bus.mem_addr_o] <= bus.mem_value_o;
        if (bus.mem_enable_o && bus.mem_rd_en_o) bus.mem_value_i <= ram[bus.mem_addr_o];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.req_i  = 2'b00;
        bus.we_i   = 2'b00;
        bus.lock_i = 2'b00;
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
        tick();
    endtask

    logic [1:0] cont_exp [4];

    initial begin
        ram[12'h010] <= 16'hBEEF;
        bus.mem_value_i = '0;
        bus.addr0_i  = '0;
        bus.addr1_i  = '0;
        bus.wdata0_i = '0;
        bus.wdata1_i = '0;
        bus.we_i     = 2'b00;
        bus.lock_i   = 2'b00;
        bus.req_i    = 2'b11;

        // Reset with both ports requesting.
        rst_i = 1'b1;
        tick();
        settle();
        check_eq("rst_gnt_c1", bus.gnt_o, 2'b00);
        tick();
        settle();
        check_eq("rst_gnt", bus.gnt_o, 2'b00);
        check_eq("rst_rvalid", bus.rvalid_o, 2'b00);
        check_eq("rst_mem_en", bus.mem_enable_o, 1'b0);
        check_eq("rst_mem_wr", bus.mem_wr_en_o, 1'b0);
        check_eq("rst_mem_rd", bus.mem_rd_en_o, 1'b0);
        check_eq("rst_mem_addr", bus.mem_addr_o, 12'h000);
        check_eq("rst_mem_value", bus.mem_value_o, 16'h0000);
        check_eq("rst_rdata0", bus.rdata0_o, 16'h0000);
        check_eq("rst_rdata1", bus.rdata1_o, 16'h0000);
        tick();
        rst_i = 1'b0;
        settle();
        check_eq("post_rst_first", bus.gnt_o, 2'b01);
        tick();
        drain();

        // Single read from port 0.
        bus.req_i   = 2'b01;
        bus.addr0_i = 12'h010;
        settle();
        check_eq("rd_gnt_T", bus.gnt_o, 2'b01);
        tick();
        idle();
        settle();
        check_eq("rd_mem_en_T1", bus.mem_enable_o, 1'b1);
        check_eq("rd_mem_rd_T1", bus.mem_rd_en_o, 1'b1);
        check_eq("rd_mem_wr_T1", bus.mem_wr_en_o, 1'b0);
        check_eq("rd_mem_addr_T1", bus.mem_addr_o, 12'h010);
        check_eq("rd_rvalid_T1", bus.rvalid_o, 2'b00);
        tick();
        settle();
        check_eq("rd_rvalid_T2", bus.rvalid_o, 2'b01);
        check_eq("rd_rdata0_T2", bus.rdata0_o, 16'hBEEF);
        check_eq("rd_mem_en_T2", bus.mem_enable_o, 1'b0);
        tick();
        settle();
        check_eq("rd_rvalid_T3", bus.rvalid_o, 2'b00);
        check_eq("rd_rdata0_hold", bus.rdata0_o, 16'hBEEF);
        drain();

        // Contention; last grant went to port 0.
`ifdef ARB_ROUND_ROBIN_EN
        cont_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        cont_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        bus.addr0_i = 12'h030;
        bus.addr1_i = 12'h031;
        bus.req_i   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("cont_gnt%0d", i), bus.gnt_o, cont_exp[i]);
            tick();
        end
        bus.req_i = 2'b10;
        settle();
        check_eq("cont_p1_alone", bus.gnt_o, 2'b10);
        tick();
        drain();

        // Lock: port 1 locks alone, then port 0 contends; MAX_LOCK=4.
        bus.addr1_i = 12'h040;
        bus.req_i   = 2'b10;
        bus.lock_i  = 2'b10;
        settle();
        check_eq("lock_gnt0", bus.gnt_o, 2'b10);
        tick();
        bus.req_i = 2'b11;
        for (int i = 1; i < 4; i++) begin
            settle();
            check_eq($sformatf("lock_gnt%0d", i), bus.gnt_o, 2'b10);
            tick();
        end
        settle();
        check_eq("lock_release", bus.gnt_o, 2'b01);
        tick();
        drain();

        // Lock held with no request: idle cycle, then dropping lock reopens arbitration.
        bus.req_i  = 2'b10;
        bus.lock_i = 2'b10;
        tick();
        bus.req_i = 2'b01;
        settle();
        check_eq("lock_idle_gnt", bus.gnt_o, 2'b00);
        tick();
        bus.lock_i = 2'b00;
        settle();
        check_eq("lock_drop_gnt", bus.gnt_o, 2'b00);
        tick();
        settle();
        check_eq("lock_exit_gnt", bus.gnt_o, 2'b01);
        tick();
        drain();

        // Write from port 0 then read-after-write from port 1.
        bus.req_i    = 2'b01;
        bus.we_i     = 2'b01;
        bus.addr0_i  = 12'h020;
        bus.wdata0_i = 16'h1234;
        settle();
        check_eq("raw_wr_gnt", bus.gnt_o, 2'b01);
        tick();
        bus.req_i   = 2'b10;
        bus.we_i    = 2'b00;
        bus.addr1_i = 12'h020;
        settle();
        check_eq("raw_rd_gnt", bus.gnt_o, 2'b10);
        check_eq("raw_mem_wr", bus.mem_wr_en_o, 1'b1);
        check_eq("raw_mem_rd", bus.mem_rd_en_o, 1'b0);
        check_eq("raw_mem_value", bus.mem_value_o, 16'h1234);
        check_eq("raw_mem_addr", bus.mem_addr_o, 12'h020);
        tick();
        idle();
        settle();
        check_eq("raw_rvalid_wr", bus.rvalid_o, 2'b00);
        check_eq("raw_mem_rd_T2", bus.mem_rd_en_o, 1'b1);
        tick();
        settle();
        check_eq("raw_rvalid", bus.rvalid_o, 2'b10);
        check_eq("raw_rdata1", bus.rdata1_o, 16'h1234);
        drain();

        // Reset while a port 0 read is in flight.
        bus.req_i   = 2'b01;
        bus.addr0_i = 12'h010;
        settle();
        check_eq("mrst_gnt_T", bus.gnt_o, 2'b01);
        tick();
        rst_i = 1'b1;
        settle();
        check_eq("mrst_gnt_T1", bus.gnt_o, 2'b00);
        tick();
        rst_i     = 1'b0;
        bus.req_i = 2'b11;
        settle();
        check_eq("mrst_rvalid_T2", bus.rvalid_o, 2'b00);
        check_eq("mrst_mem_rd_T2", bus.mem_rd_en_o, 1'b0);
        check_eq("mrst_arb_gnt", bus.gnt_o, 2'b01);
        tick();
        idle();
        settle();
        check_eq("mrst_rvalid_T3", bus.rvalid_o, 2'b00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port 16-bit synchronous memory between the CPU and a second master (loader/debug DMA). It sits between the requesters and `memory`, drives that memory's address/enable/read/write/data pins from registered outputs, and routes read data back to the owning requester. It supports per-cycle arbitration with optional bounded burst locking.

## Interface
- ADDR_WIDTH, 12, word address width (memory depth 2**ADDR_WIDTH × 16 bit)
- DATA_WIDTH, 16, data word width
- MAX_LOCK, 8, maximum consecutive grants to one locked requester (≥1)
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  2  per-port access request; bit p = port p
- we_i  in  2  per-port write (1) / read (0) qualifier
- lock_i  in  2  per-port burst-lock request
- addr0_i, addr1_i  in  ADDR_WIDTH  per-port word address
- wdata0_i, wdata1_i  in  DATA_WIDTH  per-port write data
- gnt_o  out  2  per-port grant (combinational, one-hot or zero)
- rvalid_o  out  2  per-port read-data valid
- rdata0_o, rdata1_o  out  DATA_WIDTH  per-port read data
- mem_addr_o  out  ADDR_WIDTH  memory address (registered)
- mem_value_o  out  DATA_WIDTH  memory write data (registered)
- mem_value_i  in  DATA_WIDTH  memory read data (valid the cycle after a read command)
- mem_enable_o, mem_wr_en_o, mem_rd_en_o  out  1 each  memory enable/write/read (registered)

## Operation
- Handshake: requester holds req/we/addr/wdata/lock stable until it samples gnt_o[p]=1 at a rising edge; that edge accepts the access. At most one grant per cycle; one access per grant.
- Accepted access registers into mem_* outputs; mem_enable_o=1, exactly one of mem_wr_en_o/mem_rd_en_o=1 for one cycle; all zero in cycles with no accepted access.
- Read tracking: 2-stage owner pipeline (valid + port id); rvalid_o[owner]=1 and rdata<owner>_o=mem_value_i when stage 2 is valid. rdata of non-valid port holds last value. Writes produce no rvalid.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB: winner chosen per Configuration policy. If winner has lock_i=1 on acceptance → LOCKp, lock counter=1 (MAX_LOCK=1 stays in ARB).
  - LOCKp: only port p can be granted; other port's gnt=0. Each grant increments counter. Exit to ARB when lock_i[p]=0 while req_i[p]=0, when lock_i[p] drops, or when the grant making counter==MAX_LOCK is accepted. Lock exit counts port p as last-granted.
  - LOCKp with req_i[p]=0 and lock_i[p]=1: idle cycle, no grant, counter unchanged.
- Counter width $clog2(MAX_LOCK+1); never wraps.
- Reset: gnt_o=0, rvalid_o=0, rdata*_o=0, all mem_* outputs=0, state ARB, owner pipeline cleared (in-flight reads dropped, no rvalid), last-granted=port 1 (port 0 wins first).

## Timing
- Cycle T: gnt_o[p]=1, accepted at end of T.
- T+1: memory command on mem_* outputs.
- T+2: read data returned; rvalid_o[p]=1. Read latency = 2 cycles from acceptance.
- Back-to-back: throughput one access/cycle. A write accepted in T followed by a read of the same address accepted in T+1 returns the new data.
- rst_i high in any cycle overrides grants that cycle (gnt_o=0).

## Configuration
- ARB_ROUND_ROBIN_EN defined: in ARB, on contention, grant the port not granted last; uncontended requester always granted.
- Undefined: fixed priority, port 0 always wins in ARB; port 1 granted only when req_i[0]=0. Lock behaviour identical in both builds.

## Structure
- Package mem_arb_pkg: arb_state_t enum (ARB, LOCK0, LOCK1), port-id typedef, NUM_PORTS=2 constant, read-owner pipeline struct.
- Sub-module mem_arb_rr_pick: combinational 2-way pick (request vector + last-granted → one-hot grant), macro-selected policy inside.

## Test plan
- Reset: rst_i high 2 cycles with req_i=2'b11 → all outputs 0; after release, port 0 granted first.
- Single read: ram[0x010]=16'hBEEF, port 0 read 0x010 → gnt_o=01 in T, mem_rd_en_o=1 and mem_addr_o=0x010 in T+1, rvalid_o=01 and rdata0_o=16'hBEEF in T+2.
- Contention, both ports reading continuously: with ARB_ROUND_ROBIN_EN grants alternate 01,10,01,10; without it gnt_o=01 every cycle until req_i[0] drops.
- Lock, MAX_LOCK=4: port 1 locked and requesting, port 0 requesting → exactly 4 consecutive gnt_o=10, then gnt_o=01.
- Write/read-after-write: port 0 write 16'h1234 to 0x020 in T, port 1 read 0x020 accepted T+1 → rvalid_o=10 and rdata1_o=16'h1234 in T+3.
- Reset mid-operation: rst_i asserted in T+1 after a port 0 read accepted in T → rvalid_o stays 0, state ARB.
